// File: rtl/ltc_frame_sched_pkg.sv
// Shared definitions for the LTC frame scheduler: rate codes, frame geometry,
// scheduler states and the elaboration-time phase-step calculation.
package ltc_pkg;

  localparam logic [1:0] RATE_24 = 2'b00;
  localparam logic [1:0] RATE_25 = 2'b01;
  localparam logic [1:0] RATE_30 = 2'b10;

  localparam int unsigned LTC_BITS       = 80;
  localparam int unsigned HALF_PER_FRAME = 160;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // floor(2^acc_w * 160 * fps / freq_i); the reserved code falls back to 30 fps
  function automatic longint unsigned step_for(input logic [1:0] rate,
                                               input longint unsigned freq_i,
                                               input int unsigned acc_w);
    longint unsigned fps;
    case (rate)
      RATE_24: fps = 64'd24;
      RATE_25: fps = 64'd25;
      default: fps = 64'd30;
    endcase
    return ((64'd1 << acc_w) * 64'(HALF_PER_FRAME) * fps) / freq_i;
  endfunction

endpackage

// File: rtl/ltc_frame_sched_if.sv
// Control and timing-strobe bundle between the LTC scheduler and its consumers.
interface ltc_frame_sched_if;
  logic       enable_i;
  logic [1:0] rate_sel_i;
  logic       half_tick_o;
  logic       bit_tick_o;
  logic       frame_start_o;
  logic [6:0] bit_idx_o;
  logic       half_o;
  logic [1:0] rate_o;
  logic       busy_o;

  modport master (
    output enable_i, rate_sel_i,
    input  half_tick_o, bit_tick_o, frame_start_o, bit_idx_o, half_o, rate_o, busy_o
  );

  modport slave (
    input  enable_i, rate_sel_i,
    output half_tick_o, bit_tick_o, frame_start_o, bit_idx_o, half_o, rate_o, busy_o
  );
endinterface

// File: rtl/ltc_frame_sched_phase_acc.sv
// Fractional phase accumulator; carry is combinational so the scheduler can
// register its strobe on the same edge the accumulator wraps.
module ltc_phase_acc #(
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [ACC_W-1:0] step,
  output logic             carry
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, step};

  // The residue is kept on wrap so the long-term rate stays exact
  always_comb begin
    acc_d = acc_q;
    carry = 1'b0;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum[ACC_W-1:0];
      carry = sum[ACC_W];
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/ltc_frame_sched.sv
// LTC transmit scheduler: half-bit/bit/frame strobes and bit index for an
// 80-bit frame, with frame-rate changes applied only at frame boundaries.
module ltc_frame_sched
  import ltc_pkg::*;
#(
  parameter int unsigned FREQ_I = 50_000_000,
  parameter int unsigned ACC_W  = 32
) (
  input logic               clk_i,
  input logic               reset,
  ltc_frame_sched_if.slave  bus
);

  localparam logic [ACC_W-1:0] STEP_24  = ACC_W'(step_for(RATE_24, 64'(FREQ_I), ACC_W));
  localparam logic [ACC_W-1:0] STEP_25  = ACC_W'(step_for(RATE_25, 64'(FREQ_I), ACC_W));
  localparam logic [ACC_W-1:0] STEP_30  = ACC_W'(step_for(RATE_30, 64'(FREQ_I), ACC_W));
  localparam logic [6:0]       LAST_BIT = 7'(LTC_BITS - 1);

  state_t           state_q, state_d;
  logic [1:0]       rate_q, rate_d;
  logic [6:0]       bit_idx_q, bit_idx_d;
  logic             half_q, half_d;
  logic             busy_q, busy_d;
  logic             half_tick_q, half_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             frame_start_q, frame_start_d;
  logic             acc_en, acc_clr, carry;
  logic [ACC_W-1:0] step;

  always_comb begin
    case (rate_q)
      RATE_24: step = STEP_24;
      RATE_25: step = STEP_25;
      default: step = STEP_30;
    endcase
  end

  assign acc_en = (state_q != IDLE);

  ltc_phase_acc #(.ACC_W(ACC_W)) u_acc (
    .clk_i (clk_i),
    .reset (reset),
    .en    (acc_en),
    .clr   (acc_clr),
    .step  (step),
    .carry (carry)
  );

  always_comb begin
    state_d       = state_q;
    rate_d        = rate_q;
    bit_idx_d     = bit_idx_q;
    half_d        = half_q;
    busy_d        = busy_q;
    half_tick_d   = 1'b0;
    bit_tick_d    = 1'b0;
    frame_start_d = 1'b0;
    acc_clr       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          state_d       = RUN;
          rate_d        = bus.rate_sel_i;
          acc_clr       = 1'b1;
          bit_idx_d     = '0;
          half_d        = 1'b0;
          busy_d        = 1'b1;
          half_tick_d   = 1'b1;
          bit_tick_d    = 1'b1;
          frame_start_d = 1'b1;
        end
      end
      RUN, DRAIN: begin
        state_d = bus.enable_i ? RUN : DRAIN;
        if (carry) begin
          half_tick_d = 1'b1;
          if (!half_q) begin
            half_d = 1'b1;
          end else if (bit_idx_q != LAST_BIT) begin
            half_d     = 1'b0;
            bit_idx_d  = bit_idx_q + 7'd1;
            bit_tick_d = 1'b1;
          end else begin
            half_d    = 1'b0;
            bit_idx_d = '0;
            // Frame boundary: continue with the newly requested rate, or stop silently
            if (bus.enable_i) begin
              bit_tick_d    = 1'b1;
              frame_start_d = 1'b1;
              rate_d        = bus.rate_sel_i;
            end else begin
              state_d     = IDLE;
              busy_d      = 1'b0;
              half_tick_d = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rate_q        <= RATE_25;
      bit_idx_q     <= '0;
      half_q        <= 1'b0;
      busy_q        <= 1'b0;
      half_tick_q   <= 1'b0;
      bit_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rate_q        <= rate_d;
      bit_idx_q     <= bit_idx_d;
      half_q        <= half_d;
      busy_q        <= busy_d;
      half_tick_q   <= half_tick_d;
      bit_tick_q    <= bit_tick_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.half_tick_o   = half_tick_q;
  assign bus.bit_tick_o    = bit_tick_q;
  assign bus.frame_start_o = frame_start_q;
  assign bus.bit_idx_o     = bit_idx_q;
  assign bus.half_o        = half_q;
  assign bus.rate_o        = rate_q;
  assign bus.busy_o        = busy_q;

endmodule

// File: tb/tb_ltc_frame_sched.sv
// Bench for ltc_frame_sched; the clock is scaled to 100 kHz so multi-frame
// scenarios stay short (25 fps -> 25/26-cycle half-bits, 4000/4001-cycle frames).
module tb_ltc_frame_sched;
  import ltc_pkg::*;

  localparam int unsigned FREQ = 100_000;

  typedef struct {
    logic [1:0] rate_sel;
    int         frames;
    logic [1:0] exp_rate;
    int         half_lo;
    int         frame_lo;
  } vec_t;

  typedef struct {
    int         len;
    logic [1:0] rate;
  } ival_t;

  logic clk_i = 1'b0;
  logic rst   = 1'b1;
  always #5 clk_i = ~clk_i;

  ltc_frame_sched_if bus ();

  ltc_frame_sched #(.FREQ_I(FREQ), .ACC_W(32)) dut (
    .clk_i (clk_i),
    .reset (rst),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  ival_t      int_log[$];
  int         per_log[$];
  logic [1:0] exp_fs_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input longint act,
                             input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic budget_check(input string name, input bit ok, input int budget);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: event not seen within %0d cycles, required", name, budget);
    end
  endtask

  // Free-running observer: walks its own bit/half model and logs intervals
  task automatic monitor();
    int         last_half = 0, last_fs = 0, m_idx = 0;
    bit         have_half = 0, have_fs = 0, in_frame = 0, prev_half = 0, m_half = 0;
    logic [1:0] rate_prev = 2'b00;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (rst || !bus.busy_o) begin
        have_half = 0; have_fs = 0; in_frame = 0;
      end
      if (!rst && (bus.half_tick_o || bus.bit_tick_o || bus.frame_start_o)) begin
        check("strobe_when_busy", bus.busy_o, 1);
        check("bit_implies_half", bus.half_tick_o, 1);
        check("strobe_width", prev_half, 0);
        if (bus.frame_start_o) begin
          check("fs_bit_idx", bus.bit_idx_o, 0);
          check("fs_half", bus.half_o, 0);
          check("fs_bit_tick", bus.bit_tick_o, 1);
          if (exp_fs_q.size() == 0) check("fs_unexpected_queue", exp_fs_q.size(), 1);
          else                      check("fs_rate", bus.rate_o, exp_fs_q.pop_front());
          if (have_fs) per_log.push_back(cyc - last_fs);
          last_fs = cyc; have_fs = 1; in_frame = 1; m_idx = 0; m_half = 0;
        end else if (in_frame) begin
          if (!m_half) m_half = 1;
          else begin m_half = 0; m_idx++; end
          check("walk_idx", bus.bit_idx_o, m_idx);
          check("walk_half", bus.half_o, m_half);
          check("walk_bit_tick", bus.bit_tick_o, !m_half);
        end
        if (have_half) int_log.push_back('{len: cyc - last_half, rate: rate_prev});
        last_half = cyc; have_half = 1; rate_prev = bus.rate_o;
      end
      prev_half = bus.half_tick_o;
    end
  endtask

  task automatic wait_fs(input string name, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (bus.frame_start_o) begin ok = 1; break; end
    end
    budget_check(name, ok, budget);
    #1;
  endtask

  task automatic wait_tick(input string name, input int idx, input bit half, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (bus.half_tick_o && bus.bit_idx_o == 7'(idx) && bus.half_o == half) begin ok = 1; break; end
    end
    budget_check(name, ok, budget);
    #1;
  endtask

  task automatic quiet(input string name, input int n);
    int cnt = 0;
    repeat (n) begin
      @(negedge clk_i);
      if (bus.half_tick_o || bus.bit_tick_o || bus.frame_start_o || bus.busy_o) cnt++;
    end
    check(name, cnt, 0);
  endtask

  task automatic do_reset();
    check("sb_drained", exp_fs_q.size(), 0);
    exp_fs_q.delete();
    @(negedge clk_i);
    rst = 1'b1;
    bus.enable_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst = 1'b0;
    #1;
  endtask

  task automatic start_run(input logic [1:0] sel, input logic [1:0] exp_rate, input int n_fs);
    @(negedge clk_i);
    repeat (n_fs) exp_fs_q.push_back(exp_rate);
    check("pre_start_busy", bus.busy_o, 0);
    bus.rate_sel_i = sel;
    bus.enable_i   = 1'b1;
    @(negedge clk_i);
    #1;
    check("start_fs", bus.frame_start_o, 1);
    check("start_bit_tick", bus.bit_tick_o, 1);
    check("start_half_tick", bus.half_tick_o, 1);
    check("start_busy", bus.busy_o, 1);
    check("start_rate", bus.rate_o, exp_rate);
    check("start_idx", bus.bit_idx_o, 0);
  endtask

  task automatic check_logs(input string tag, input int i0, input int p0, input logic [1:0] rate,
                            input int half_lo, input int frame_lo, input int exp_n, input int exp_p);
    int mn = 1_000_000, mx = 0, bad_rate = 0;
    for (int i = i0; i < int_log.size(); i++) begin
      if (int_log[i].len < mn) mn = int_log[i].len;
      if (int_log[i].len > mx) mx = int_log[i].len;
      if (int_log[i].rate != rate) bad_rate++;
    end
    check({tag, "_half_count"}, int_log.size() - i0, exp_n);
    check_range({tag, "_min_ival"}, mn, half_lo, half_lo + 1);
    check_range({tag, "_max_ival"}, mx, half_lo, half_lo + 1);
    check({tag, "_ival_rate"}, bad_rate, 0);
    check({tag, "_period_count"}, per_log.size() - p0, exp_p);
    for (int i = p0; i < per_log.size(); i++)
      check_range({tag, "_period"}, per_log[i], frame_lo, frame_lo + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required earlier finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   i0, p0, last_idx, last_half, last_cyc;
    bit   ok;

    vecs[0] = '{rate_sel: 2'b01, frames: 2, exp_rate: 2'b01, half_lo: 25, frame_lo: 4000};
    vecs[1] = '{rate_sel: 2'b00, frames: 3, exp_rate: 2'b00, half_lo: 26, frame_lo: 4166};
    vecs[2] = '{rate_sel: 2'b10, frames: 1, exp_rate: 2'b10, half_lo: 20, frame_lo: 3333};
    vecs[3] = '{rate_sel: 2'b11, frames: 1, exp_rate: 2'b11, half_lo: 20, frame_lo: 3333};

    bus.enable_i   = 1'b0;
    bus.rate_sel_i = 2'b00;
    fork monitor(); join_none

    repeat (2) @(negedge clk_i);
    check("rst_busy", bus.busy_o, 0);
    check("rst_half_tick", bus.half_tick_o, 0);
    check("rst_bit_tick", bus.bit_tick_o, 0);
    check("rst_fs", bus.frame_start_o, 0);
    check("rst_idx", bus.bit_idx_o, 0);
    check("rst_half", bus.half_o, 0);
    check("rst_rate", bus.rate_o, 1);
    rst = 1'b0;
    quiet("idle_quiet_boot", 50);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      i0 = int_log.size();
      p0 = per_log.size();
      start_run(vecs[v].rate_sel, vecs[v].exp_rate, vecs[v].frames + 1);
      for (int f = 0; f < vecs[v].frames; f++) wait_fs("vec_fs", 5000);
      check("vec_rate", bus.rate_o, vecs[v].exp_rate);
      check_logs($sformatf("vec%0d", v), i0, p0, vecs[v].exp_rate,
                 vecs[v].half_lo, vecs[v].frame_lo, 160 * vecs[v].frames, vecs[v].frames);
      $display("vector %0d rate_sel=%0d frames=%0d done", v, vecs[v].rate_sel, vecs[v].frames);
    end

    // Rate request changes mid-frame; must only take effect at the boundary
    do_reset();
    start_run(2'b01, 2'b01, 1);
    wait_tick("chg_bit40", 40, 1'b0, 3000);
    bus.rate_sel_i = 2'b10;
    exp_fs_q.push_back(2'b10);
    exp_fs_q.push_back(2'b10);
    check("chg_rate_hold", bus.rate_o, 1);
    wait_tick("chg_bit79", 79, 1'b1, 3000);
    check("chg_rate_hold_end", bus.rate_o, 1);
    wait_fs("chg_fs1", 200);
    check("chg_rate_new", bus.rate_o, 2);
    i0 = int_log.size();
    p0 = per_log.size();
    wait_fs("chg_fs2", 5000);
    check_logs("chg", i0, p0, 2'b10, 20, 3333, 160, 1);
    $display("sequence rate_change done");

    // Enable dropped at bit 10: frame runs out silently, then idle
    do_reset();
    start_run(2'b01, 2'b01, 1);
    wait_tick("drain_bit10", 10, 1'b0, 1000);
    bus.enable_i = 1'b0;
    ok = 0; last_idx = -1; last_half = -1; last_cyc = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk_i);
      if (bus.half_tick_o) begin last_idx = bus.bit_idx_o; last_half = bus.half_o; last_cyc = cyc; end
      if (!bus.busy_o) begin ok = 1; break; end
    end
    budget_check("drain_busy_fall", ok, 5000);
    check("drain_last_idx", last_idx, 79);
    check("drain_last_half", last_half, 1);
    check_range("drain_boundary_gap", cyc - last_cyc, 25, 26);
    check("drain_idx_zero", bus.bit_idx_o, 0);
    check("drain_half_zero", bus.half_o, 0);
    check("drain_no_half_tick", bus.half_tick_o, 0);
    check("drain_no_fs", bus.frame_start_o, 0);
    quiet("drain_idle_quiet", 300);
    $display("sequence drain done");

    // Enable dropped then re-raised inside the same frame: timing undisturbed
    do_reset();
    i0 = int_log.size();
    p0 = per_log.size();
    start_run(2'b01, 2'b01, 2);
    wait_tick("rearm_bit10", 10, 1'b0, 1000);
    bus.enable_i = 1'b0;
    wait_tick("rearm_bit50", 50, 1'b0, 3000);
    bus.enable_i = 1'b1;
    check("rearm_busy", bus.busy_o, 1);
    wait_fs("rearm_fs", 3000);
    check_logs("rearm", i0, p0, 2'b01, 25, 4000, 160, 1);
    $display("sequence rearm done");

    // Asynchronous reset mid-frame clears everything without waiting for a clock edge
    do_reset();
    start_run(2'b10, 2'b10, 1);
    wait_tick("arst_bit37", 37, 1'b1, 2000);
    rst = 1'b1;
    bus.enable_i = 1'b0;
    #1;
    check("arst_half_tick", bus.half_tick_o, 0);
    check("arst_bit_tick", bus.bit_tick_o, 0);
    check("arst_fs", bus.frame_start_o, 0);
    check("arst_busy", bus.busy_o, 0);
    check("arst_idx", bus.bit_idx_o, 0);
    check("arst_half", bus.half_o, 0);
    check("arst_rate", bus.rate_o, 1);
    repeat (3) @(negedge clk_i);
    rst = 1'b0;
    quiet("arst_idle_quiet", 100);
    start_run(2'b01, 2'b01, 1);
    $display("sequence async_reset done");

    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
